// File: rtl/draw_pkg.sv
// Shared canvas geometry, point record and interpolator state encoding
// for the drawing pipeline.
package draw_pkg;

    localparam int X_W       = 10;
    localparam int Y_W       = 9;
    localparam int COLOR_W   = 4;
    localparam int SW_W      = 3;
    localparam int X_MAX     = 319;
    localparam int Y_MAX     = 179;
    localparam int MAX_STEPS = 64;

    // Bresenham error term: one sign bit plus one bit of headroom for 2*err.
    localparam int ERR_W = ((X_W > Y_W) ? X_W : Y_W) + 2;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
        logic [SW_W-1:0]    sw;
    } point_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STEP,
        EMIT_LAST
    } interp_state_t;

endpackage

// File: rtl/line_stepper.sv
// Bresenham datapath: load computes the line terms and takes the first step at
// once; advance takes further steps. The registered position is the point on show.
module line_stepper
    import draw_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           advance,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    output logic [X_W-1:0] step_x,
    output logic [Y_W-1:0] step_y,
    output logic [X_W-1:0] span,
    output logic           done
);

    logic [X_W-1:0]          cur_x, end_x, adx, src_x;
    logic [Y_W-1:0]          cur_y, end_y, ady, src_y;
    logic signed [ERR_W-1:0] err, dx, dy;
    logic signed [ERR_W-1:0] ld_dx, ld_dy, src_err, use_dx, use_dy, e2, nxt_err;
    logic                    x_neg, y_neg, use_xn, use_yn;

    always_comb begin
        adx     = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
        ady     = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
        span    = (adx >= X_W'(ady)) ? adx : X_W'(ady);
        ld_dx   = ERR_W'(adx);
        ld_dy   = -ERR_W'(ady);
        src_x   = load ? x0 : cur_x;
        src_y   = load ? y0 : cur_y;
        src_err = load ? (ld_dx + ld_dy) : err;
        use_dx  = load ? ld_dx : dx;
        use_dy  = load ? ld_dy : dy;
        use_xn  = load ? (x1 < x0) : x_neg;
        use_yn  = load ? (y1 < y0) : y_neg;
        e2      = src_err <<< 1;
        step_x  = src_x;
        step_y  = src_y;
        nxt_err = src_err;
        if (e2 >= use_dy) begin
            nxt_err = nxt_err + use_dy;
            step_x  = use_xn ? (src_x - X_W'(1)) : (src_x + X_W'(1));
        end
        if (e2 <= use_dx) begin
            nxt_err = nxt_err + use_dx;
            step_y  = use_yn ? (src_y - Y_W'(1)) : (src_y + Y_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x <= '0;
            cur_y <= '0;
            end_x <= '0;
            end_y <= '0;
            err   <= '0;
            dx    <= '0;
            dy    <= '0;
            x_neg <= 1'b0;
            y_neg <= 1'b0;
        end else if (load) begin
            cur_x <= step_x;
            cur_y <= step_y;
            err   <= nxt_err;
            dx    <= ld_dx;
            dy    <= ld_dy;
            x_neg <= use_xn;
            y_neg <= use_yn;
            end_x <= x1;
            end_y <= y1;
        end else if (advance) begin
            cur_x <= step_x;
            cur_y <= step_y;
            err   <= nxt_err;
        end
    end

    assign done = (cur_x == end_x) && (cur_y == end_y);

endmodule

// File: rtl/stroke_interp.sv
// Turns one cursor sample per frame into the continuous run of canvas pixels
// joining it to the previous sample, one point per output handshake.
module stroke_interp
    import draw_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               in_valid_in,
    output logic               in_ready_out,
    input  logic               pen_down_in,
    input  logic [X_W-1:0]     x_in,
    input  logic [Y_W-1:0]     y_in,
    input  logic [COLOR_W-1:0] color_in,
    input  logic [SW_W-1:0]    sw_in,
    output logic               pt_valid_out,
    input  logic               pt_ready_in,
    output logic [X_W-1:0]     pt_x_out,
    output logic [Y_W-1:0]     pt_y_out,
    output logic [COLOR_W-1:0] pt_color_out,
    output logic [SW_W-1:0]    pt_sw_out,
    output logic               busy_out,
    output logic [7:0]         drop_cnt_out
);

    interp_state_t  state, next_state;
    point_t         slot_pt, work_pt, pt_q;
    logic           slot_full, slot_pen, work_pen, prev_valid;
    logic [X_W-1:0] prev_x, clamp_x, step_x, span;
    logic [Y_W-1:0] prev_y, clamp_y, step_y;
    logic           accept, pt_take, seg_done, single_pt, same_pt;
    logic           take_slot, st_load, st_adv, emit_end, emit_step, retire;

    assign accept    = in_valid_in & in_ready_out;
    assign pt_take   = pt_valid_out & pt_ready_in;
    assign clamp_x   = (x_in > X_W'(X_MAX)) ? X_W'(X_MAX) : x_in;
    assign clamp_y   = (y_in > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : y_in;
    assign single_pt = !prev_valid || !work_pen || (span > X_W'(MAX_STEPS));
    assign same_pt   = (work_pt.x == prev_x) && (work_pt.y == prev_y);

    line_stepper u_stepper (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .load    (st_load),
        .advance (st_adv),
        .x0      (prev_x),
        .y0      (prev_y),
        .x1      (work_pt.x),
        .y1      (work_pt.y),
        .step_x  (step_x),
        .step_y  (step_y),
        .span    (span),
        .done    (seg_done)
    );

    always_comb begin
        next_state = state;
        take_slot  = 1'b0;
        st_load    = 1'b0;
        st_adv     = 1'b0;
        emit_end   = 1'b0;
        emit_step  = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                if (slot_full) begin
                    take_slot  = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                if (single_pt) begin
                    emit_end   = 1'b1;
                    next_state = EMIT_LAST;
                end else if (same_pt) begin
                    next_state = IDLE;
                end else begin
                    st_load    = 1'b1;
                    emit_step  = 1'b1;
                    next_state = STEP;
                end
            end
            STEP: begin
                if (pt_take) begin
                    if (seg_done) begin
                        retire     = 1'b1;
                        next_state = IDLE;
                    end else begin
                        st_adv    = 1'b1;
                        emit_step = 1'b1;
                    end
                end
            end
            EMIT_LAST: begin
                if (pt_take) begin
                    retire     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= next_state;
    end

    // A newer sample always wins the slot; losing an unconsumed one counts as a drop.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            in_ready_out <= 1'b0;
            slot_full    <= 1'b0;
            slot_pt      <= '0;
            slot_pen     <= 1'b0;
            drop_cnt_out <= '0;
        end else begin
            in_ready_out <= 1'b1;
            if (accept) begin
                slot_pt   <= '{x: clamp_x, y: clamp_y, color: color_in, sw: sw_in};
                slot_pen  <= pen_down_in;
                slot_full <= 1'b1;
                if (slot_full && !take_slot && (drop_cnt_out != 8'hFF))
                    drop_cnt_out <= drop_cnt_out + 8'd1;
            end else if (take_slot) begin
                slot_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            work_pt    <= '0;
            work_pen   <= 1'b0;
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
        end else begin
            if (take_slot) begin
                work_pt  <= slot_pt;
                work_pen <= slot_pen;
            end
            if (state == SETUP) begin
                prev_x     <= work_pt.x;
                prev_y     <= work_pt.y;
                prev_valid <= work_pen;
            end
        end
    end

    // Output register only changes on emit or after a handshake, so it holds under backpressure.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pt_valid_out <= 1'b0;
            pt_q         <= '0;
        end else if (emit_end) begin
            pt_valid_out <= 1'b1;
            pt_q         <= work_pt;
        end else if (emit_step) begin
            pt_valid_out <= 1'b1;
            pt_q         <= '{x: step_x, y: step_y, color: work_pt.color, sw: work_pt.sw};
        end else if (retire) begin
            pt_valid_out <= 1'b0;
        end
    end

    assign pt_x_out     = pt_q.x;
    assign pt_y_out     = pt_q.y;
    assign pt_color_out = pt_q.color;
    assign pt_sw_out    = pt_q.sw;
    assign busy_out     = (state != IDLE);

endmodule

// File: tb/tb_stroke_interp.sv
// Randomised scoreboard bench for stroke_interp: a line-drawing reference model
// queues expected points and a negedge monitor pops them on every output handshake.
module tb_stroke_interp;
    import draw_pkg::*;

    typedef struct {
        int x;
        int y;
        int color;
        int sw;
    } exp_pt_t;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               in_valid_in;
    logic               in_ready_out;
    logic               pen_down_in;
    logic [X_W-1:0]     x_in;
    logic [Y_W-1:0]     y_in;
    logic [COLOR_W-1:0] color_in;
    logic [SW_W-1:0]    sw_in;
    logic               pt_valid_out;
    logic               pt_ready_in;
    logic [X_W-1:0]     pt_x_out;
    logic [Y_W-1:0]     pt_y_out;
    logic [COLOR_W-1:0] pt_color_out;
    logic [SW_W-1:0]    pt_sw_out;
    logic               busy_out;
    logic [7:0]         drop_cnt_out;

    int      checks = 0;
    int      failures = 0;
    int      ready_mode = 0;
    int      m_prev_x = 0;
    int      m_prev_y = 0;
    bit      m_prev_valid = 0;
    int      exp_drop = 0;
    exp_pt_t exp_q[$];

    always #5 clk_in = ~clk_in;

    stroke_interp dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .in_valid_in  (in_valid_in),
        .in_ready_out (in_ready_out),
        .pen_down_in  (pen_down_in),
        .x_in         (x_in),
        .y_in         (y_in),
        .color_in     (color_in),
        .sw_in        (sw_in),
        .pt_valid_out (pt_valid_out),
        .pt_ready_in  (pt_ready_in),
        .pt_x_out     (pt_x_out),
        .pt_y_out     (pt_y_out),
        .pt_color_out (pt_color_out),
        .pt_sw_out    (pt_sw_out),
        .busy_out     (busy_out),
        .drop_cnt_out (drop_cnt_out)
    );

    function automatic int pack_pt(int x, int y, int c, int s);
        return (x << 16) | (y << 7) | (c << 3) | s;
    endfunction

    function automatic int cur_pt();
        return pack_pt(int'(pt_x_out), int'(pt_y_out), int'(pt_color_out), int'(pt_sw_out));
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic pushPt(input int x, input int y, input int c, input int s);
        exp_pt_t e;
        e.x = x;
        e.y = y;
        e.color = c;
        e.sw = s;
        exp_q.push_back(e);
    endtask

    // Reference: clamp, then either a lone dot, nothing, or the Bresenham run excluding the start.
    task automatic modelSample(input int xr, input int yr, input bit pen, input int c, input int s);
        int x1, y1, x0, y0, dx, dy, sx, sy, err, e2;
        x1 = (xr > X_MAX) ? X_MAX : xr;
        y1 = (yr > Y_MAX) ? Y_MAX : yr;
        x0 = m_prev_x;
        y0 = m_prev_y;
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = (y1 > y0) ? y0 - y1 : y1 - y0;
        if (!m_prev_valid || !pen || dx > MAX_STEPS || -dy > MAX_STEPS) begin
            pushPt(x1, y1, c, s);
        end else if (!(x0 == x1 && y0 == y1)) begin
            sx = (x0 < x1) ? 1 : -1;
            sy = (y0 < y1) ? 1 : -1;
            err = dx + dy;
            while (!(x0 == x1 && y0 == y1)) begin
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x0 += sx; end
                if (e2 <= dx) begin err += dx; y0 += sy; end
                pushPt(x0, y0, c, s);
            end
        end
        m_prev_x = x1;
        m_prev_y = y1;
        m_prev_valid = pen;
    endtask

    task automatic driveSample(input int x, input int y, input bit pen, input int c, input int s,
                               input bit use_model);
        @(negedge clk_in);
        in_valid_in = 1'b1;
        x_in = X_W'(x);
        y_in = Y_W'(y);
        pen_down_in = pen;
        color_in = COLOR_W'(c);
        sw_in = SW_W'(s);
        checkOutput("in_ready", int'(in_ready_out), 1);
        if (use_model) modelSample(x, y, pen, c, s);
    endtask

    task automatic endSample();
        @(negedge clk_in);
        in_valid_in = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        repeat (2) @(negedge clk_in);
        while ((exp_q.size() != 0 || busy_out || pt_valid_out) && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput("drain", exp_q.size(), 0);
        checkOutput("idle_busy", int'(busy_out), 0);
    endtask

    task automatic applyStimulus(input int x, input int y, input bit pen, input int c, input int s);
        driveSample(x, y, pen, c, s, 1'b1);
        endSample();
        waitIdle();
    endtask

    task automatic doReset();
        @(negedge clk_in);
        rst_in = 1'b0;
        in_valid_in = 1'b0;
        exp_q.delete();
        m_prev_valid = 0;
        exp_drop = 0;
        repeat (2) @(negedge clk_in);
        checkOutput("rst_pt_valid", int'(pt_valid_out), 0);
        checkOutput("rst_in_ready", int'(in_ready_out), 0);
        checkOutput("rst_busy", int'(busy_out), 0);
        checkOutput("rst_drop", int'(drop_cnt_out), 0);
        checkOutput("rst_pt", cur_pt(), 0);
        rst_in = 1'b1;
        @(negedge clk_in);
        checkOutput("ready_after_rst", int'(in_ready_out), 1);
    endtask

    // Monitor: drives pt_ready_in, checks holding under backpressure, scores every handshake.
    initial begin : monitor
        bit      held;
        int      held_pt;
        exp_pt_t e;
        held = 0;
        held_pt = 0;
        pt_ready_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                held = 0;
            end else begin
                if (held) begin
                    checkOutput("hold_valid", int'(pt_valid_out), 1);
                    checkOutput("hold_pt", cur_pt(), held_pt);
                end
                case (ready_mode)
                    0:       pt_ready_in = 1'b1;
                    1:       pt_ready_in = !pt_ready_in;
                    2:       pt_ready_in = 1'($urandom_range(0, 1));
                    default: pt_ready_in = 1'b0;
                endcase
                if (pt_valid_out && pt_ready_in) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("extra_pt", cur_pt(), -1);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("pt", cur_pt(), pack_pt(e.x, e.y, e.color, e.sw));
                    end
                end
                held = pt_valid_out && !pt_ready_in;
                held_pt = cur_pt();
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n, x, y, c, s;
        bit pen;
        rst_in = 1'b0;
        in_valid_in = 1'b0;
        pen_down_in = 1'b0;
        x_in = '0;
        y_in = '0;
        color_in = '0;
        sw_in = '0;
        doReset();

        // First sample after reset: dot at (10,5) two cycles after acceptance.
        @(negedge clk_in);
        in_valid_in = 1'b1;
        x_in = 10'd10;
        y_in = 9'd5;
        pen_down_in = 1'b1;
        color_in = 4'd3;
        sw_in = 3'd1;
        modelSample(10, 5, 1'b1, 3, 1);
        @(negedge clk_in);
        in_valid_in = 1'b0;
        checkOutput("lat_n", int'(pt_valid_out), 0);
        @(negedge clk_in);
        checkOutput("lat_n1", int'(pt_valid_out), 0);
        checkOutput("lat_busy", int'(busy_out), 1);
        @(negedge clk_in);
        checkOutput("lat_n2", int'(pt_valid_out), 1);
        waitIdle();
        applyStimulus(14, 5, 1'b1, 5, 2);

        // (0,0) -> (3,2) at full rate, busy must fall right after the last point.
        doReset();
        applyStimulus(0, 0, 1'b1, 1, 1);
        driveSample(3, 2, 1'b1, 7, 4, 1'b1);
        endSample();
        n = 0;
        while (!pt_valid_out && n < 10) begin
            @(negedge clk_in);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput("consec_valid", int'(pt_valid_out), 1);
            @(negedge clk_in);
        end
        checkOutput("consec_end_valid", int'(pt_valid_out), 0);
        checkOutput("consec_end_busy", int'(busy_out), 0);
        waitIdle();

        // Alternating backpressure on a vertical run.
        ready_mode = 1;
        applyStimulus(20, 20, 1'b1, 9, 3);
        applyStimulus(20, 26, 1'b1, 9, 3);
        ready_mode = 0;

        // Three back-to-back samples: the middle one is overwritten.
        driveSample(50, 50, 1'b1, 2, 2, 1'b1);
        driveSample(60, 60, 1'b1, 2, 2, 1'b0);
        driveSample(70, 70, 1'b1, 2, 2, 1'b1);
        exp_drop++;
        endSample();
        waitIdle();
        checkOutput("drop_cnt", int'(drop_cnt_out), exp_drop);

        // Clamp and over-long spans.
        applyStimulus(10, 10, 1'b0, 1, 0);
        applyStimulus(500, 300, 1'b1, 4, 5);
        applyStimulus(0, 0, 1'b1, 4, 5);
        applyStimulus(100, 0, 1'b1, 4, 5);

        // Pen-up breaks the stroke.
        applyStimulus(30, 30, 1'b1, 6, 1);
        applyStimulus(40, 40, 1'b0, 6, 1);
        applyStimulus(45, 40, 1'b1, 6, 1);

        // Asynchronous reset in the middle of a stalled segment.
        applyStimulus(100, 100, 1'b1, 8, 2);
        ready_mode = 3;
        driveSample(140, 120, 1'b1, 8, 2, 1'b1);
        endSample();
        n = 0;
        while (!pt_valid_out && n < 10) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput("seg_started", int'(pt_valid_out), 1);
        #2 rst_in = 1'b0;
        #1;
        checkOutput("rst_async_valid", int'(pt_valid_out), 0);
        checkOutput("rst_async_busy", int'(busy_out), 0);
        exp_q.delete();
        m_prev_valid = 0;
        exp_drop = 0;
        @(negedge clk_in);
        rst_in = 1'b1;
        ready_mode = 0;
        repeat (5) @(negedge clk_in);
        checkOutput("rst_quiet", int'(pt_valid_out), 0);
        applyStimulus(150, 130, 1'b1, 10, 6);

        // Randomised samples, mostly near the previous point, with random backpressure.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                x = int'($urandom_range(0, 511));
                y = int'($urandom_range(0, 255));
            end else begin
                x = m_prev_x + int'($urandom_range(0, 140)) - 70;
                y = m_prev_y + int'($urandom_range(0, 140)) - 70;
                if (x < 0) x = 0;
                if (y < 0) y = 0;
            end
            pen = ($urandom_range(0, 4) != 0);
            c = int'($urandom_range(0, 15));
            s = int'($urandom_range(0, 7));
            ready_mode = int'($urandom_range(0, 2));
            applyStimulus(x, y, pen, c, s);
        end
        ready_mode = 0;
        checkOutput("final_drop_cnt", int'(drop_cnt_out), exp_drop);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
